// File: rtl/fp16_to_fixed_seq.sv
// fp16_to_fixed_seq
// ---------------------------------------------------------------------------
// Purpose:
//   Sequential converter from an IEEE-754 half-precision word to a signed
//   two's-complement fixed-point word of OUT_W = INT_W + FRAC_W bits, where
//   value = out_data / 2^FRAC_W.
//
//   It is a single-entry engine:
//     1. One word is accepted.
//     2. It is decoded.
//     3. The significand is shifted one bit per cycle into position.
//     4. The result is rounded, signed and saturated.
//     5. The result is held on a valid/ready output until consumed.
//
// Configuration macro:
//   FP16FIX_ROUND_NEAREST_EN
//     Defined   : round-to-nearest-even using the LSB, guard and sticky bits.
//     Undefined : truncate toward zero. Guard/sticky logic is not built.
//
// Parameters:
//   INT_W  : integer bits of the result, including sign (2..24)
//   FRAC_W : fractional bits of the result (0..24, INT_W+FRAC_W <= 32)
//
// Ports:
//   clk       : single clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : in_data valid
//   in_ready  : engine idle and able to accept
//   in_data   : half word {sign, exponent[4:0], mantissa[9:0]}
//   out_valid : result valid, held until out_ready
//   out_ready : consumer accepts the result
//   out_data  : two's-complement fixed-point result
//   out_ovf   : result saturated (overflow or infinity)
//   out_nan   : input was NaN, out_data is 0
// ---------------------------------------------------------------------------
module fp16_to_fixed_seq #(
    parameter int INT_W  = 8,
    parameter int FRAC_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [15:0]               in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INT_W+FRAC_W-1:0]   out_data,
    output logic                      out_ovf,
    output logic                      out_nan
);

    localparam int OUT_W = INT_W + FRAC_W;
    // Magnitude register is wide enough for the 11-bit significand shifted
    // left by up to OUT_W-1 places.
    localparam int MW    = OUT_W + 12;
    localparam int CW    = 6;

    localparam logic signed [7:0] FRAC_S = 8'(FRAC_W);
    localparam logic signed [7:0] OUT_S  = 8'(OUT_W);

    localparam logic [MW:0] LIM_POS = {{(MW-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [MW:0] LIM_NEG = {{(MW-OUT_W+1){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};

    localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        ANALYZE,
        SHIFT,
        PACK,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       word_q, word_d;
    logic [MW-1:0]     mag_q, mag_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              left_q, left_d;
    logic              force_ovf_q, force_ovf_d;
    logic              nan_q, nan_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_ovf_q, out_ovf_d;
    logic              out_nan_q, out_nan_d;
`ifdef FP16FIX_ROUND_NEAREST_EN
    logic              g_q, g_d;
    logic              s_q, s_d;
`endif

    logic [4:0]        exp_w;
    logic [9:0]        man_w;
    logic [10:0]       sig;
    logic [4:0]        e_eff;
    logic signed [7:0] k;
    logic signed [7:0] neg_k;
    logic [MW:0]       mag_r;
    logic              over;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_nan   = out_nan_q;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        left_d      = left_q;
        force_ovf_d = force_ovf_q;
        nan_d       = nan_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_nan_d   = out_nan_q;
`ifdef FP16FIX_ROUND_NEAREST_EN
        g_d         = g_q;
        s_d         = s_q;
`endif

        // Decode of the latched word.
        // Subnormals use exponent 1 with no hidden bit.
        exp_w = word_q[14:10];
        man_w = word_q[9:0];
        sig   = {exp_w != 5'd0, man_w};
        e_eff = (exp_w == 5'd0) ? 5'd1 : exp_w;
        k     = $signed({3'b000, e_eff}) - 8'sd25 + FRAC_S;
        neg_k = -k;

        // Rounded magnitude and range check used by PACK.
`ifdef FP16FIX_ROUND_NEAREST_EN
        mag_r = {1'b0, mag_q} + {{MW{1'b0}}, (g_q && (s_q || mag_q[0]))};
`else
        mag_r = {1'b0, mag_q};
`endif
        over = word_q[15] ? (mag_r > LIM_NEG) : (mag_r > LIM_POS);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d     = in_data;
                    in_ready_d = 1'b0;
                    state_d    = ANALYZE;
                end
            end

            ANALYZE: begin
                force_ovf_d = 1'b0;
                nan_d       = 1'b0;
                left_d      = 1'b0;
                cnt_d       = '0;
                mag_d       = {{(MW-11){1'b0}}, sig};
`ifdef FP16FIX_ROUND_NEAREST_EN
                g_d         = 1'b0;
                s_d         = 1'b0;
`endif
                if (exp_w == 5'd31) begin
                    mag_d = '0;
                    if (man_w != 10'd0) begin
                        nan_d = 1'b1;
                    end else begin
                        force_ovf_d = 1'b1;
                    end
                    state_d = PACK;
                end else if (man_w == 10'd0 && exp_w == 5'd0) begin
                    mag_d   = '0;
                    state_d = PACK;
                end else if (k >= OUT_S) begin
                    force_ovf_d = 1'b1;
                    state_d     = PACK;
                end else if (k >= 8'sd0) begin
                    left_d  = 1'b1;
                    cnt_d   = k[CW-1:0];
                    state_d = (k == 8'sd0) ? PACK : SHIFT;
                end else begin
                    // Beyond 12 right shifts the 11-bit significand is fully
                    // in sticky, so longer shifts give the same result.
                    cnt_d   = (neg_k > 8'sd12) ? 6'd12 : neg_k[CW-1:0];
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (left_q) begin
                    mag_d = mag_q << 1;
                end else begin
                    mag_d = mag_q >> 1;
`ifdef FP16FIX_ROUND_NEAREST_EN
                    // The newest bit shifted out is the guard.
                    // Older guard bits fold into sticky.
                    g_d   = mag_q[0];
                    s_d   = s_q | g_q;
`endif
                end
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = PACK;
                end
            end

            PACK: begin
                out_valid_d = 1'b1;
                out_nan_d   = nan_q;
                if (nan_q) begin
                    out_data_d = '0;
                    out_ovf_d  = 1'b0;
                end else if (force_ovf_q || over) begin
                    out_data_d = word_q[15] ? SAT_NEG : SAT_POS;
                    out_ovf_d  = 1'b1;
                end else begin
                    out_data_d = word_q[15] ? -mag_r[OUT_W-1:0] : mag_r[OUT_W-1:0];
                    out_ovf_d  = 1'b0;
                end
                state_d = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            mag_q       <= '0;
            cnt_q       <= '0;
            left_q      <= 1'b0;
            force_ovf_q <= 1'b0;
            nan_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_nan_q   <= 1'b0;
`ifdef FP16FIX_ROUND_NEAREST_EN
            g_q         <= 1'b0;
            s_q         <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            left_q      <= left_d;
            force_ovf_q <= force_ovf_d;
            nan_q       <= nan_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_nan_q   <= out_nan_d;
`ifdef FP16FIX_ROUND_NEAREST_EN
            g_q         <= g_d;
            s_q         <= s_d;
`endif
        end
    end

endmodule
